// File: rtl/oven_button_conditioner.sv
// Five-channel oven front-panel button conditioner: each button is synchronized,
// debounced, edge-detected and given an optional hold-to-repeat step stream.

module oven_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_btn_raw,
  input  logic [4:0] i_repeat_en,
  output logic [4:0] o_level,
  output logic [4:0] o_press,
  output logic [4:0] o_release,
  output logic [4:0] o_step
);

  localparam int NCH     = 5;
  localparam int DW      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    ST_UP          = 2'd0,
    ST_DOWN_WAIT   = 2'd1,
    ST_DOWN_REPEAT = 2'd2
  } state_t;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [DW-1:0] r_db_cnt;
    logic          r_press;
    logic          r_release;
    logic          r_step;
    logic [RW-1:0] r_rpt_cnt;
    state_t        r_state;

    logic          w_diff;
    logic          w_toggle;
    logic          w_rise;
    logic          w_fall;
    logic [RW-1:0] w_rpt_last;
    logic          w_rpt_hit;
    logic          w_rpt_inc;
    logic          w_step_nxt;
    state_t        w_state_nxt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would collapse the two synchronizer stages.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= 1'b0;
        r_sync2 <= 1'b0;
      end else begin
        r_sync1 <= i_btn_raw[g];
        r_sync2 <= r_sync1;
      end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    assign w_diff   = r_sync2 ^ r_level;
    assign w_toggle = w_diff && (r_db_cnt == DB_LAST);
    assign w_rise   = w_toggle && !r_level;
    assign w_fall   = w_toggle && r_level;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_db_cnt  <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        if (!w_diff || w_toggle) begin
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DW'(1);
        end
        if (w_toggle) begin
          r_level <= ~r_level;
        end
        r_press   <= w_rise;
        r_release <= w_fall;
      end
    end

    assign w_rpt_last = (r_state == ST_DOWN_WAIT) ? DELAY_LAST : RATE_LAST;
    assign w_rpt_hit  = i_repeat_en[g] && (r_rpt_cnt == w_rpt_last);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= ST_UP;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        ST_UP: begin
          if (w_rise) w_state_nxt = ST_DOWN_WAIT;
        end
        ST_DOWN_WAIT: begin
          if (w_fall)         w_state_nxt = ST_UP;
          else if (w_rpt_hit) w_state_nxt = ST_DOWN_REPEAT;
        end
        ST_DOWN_REPEAT: begin
          if (w_fall) w_state_nxt = ST_UP;
        end
        default: w_state_nxt = ST_UP;
      endcase
    end

    // A fall always wins over a due repeat step; a low enable pins the interval at zero.
    always_comb begin
      w_step_nxt = 1'b0;
      w_rpt_inc  = 1'b0;
      case (r_state)
        ST_UP: begin
          w_step_nxt = w_rise;
        end
        ST_DOWN_WAIT, ST_DOWN_REPEAT: begin
          if (w_fall || !i_repeat_en[g]) begin
            w_step_nxt = 1'b0;
          end else if (w_rpt_hit) begin
            w_step_nxt = 1'b1;
          end else begin
            w_rpt_inc = 1'b1;
          end
        end
        default: begin
          w_step_nxt = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rpt_cnt <= '0;
        r_step    <= 1'b0;
      end else begin
        if (w_rpt_inc) begin
          r_rpt_cnt <= r_rpt_cnt + RW'(1);
        end else begin
          r_rpt_cnt <= '0;
        end
        r_step <= w_step_nxt;
      end
    end

    assign o_level[g]   = r_level;
    assign o_press[g]   = r_press;
    assign o_release[g] = r_release;
    assign o_step[g]    = r_step;
  end

endmodule

// File: tb/tb_oven_button_conditioner.sv
// Randomized and directed bench for oven_button_conditioner; expected outputs come
// from a timestamp/history-window model of the debounce and repeat rules.

module tb_oven_button_conditioner;

  localparam int D    = 4;
  localparam int RD   = 10;
  localparam int RR   = 3;
  localparam int NCH  = 5;
  localparam int HMAX = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn = '0;
  logic [4:0] ren = '0;
  logic [4:0] o_level;
  logic [4:0] o_press;
  logic [4:0] o_release;
  logic [4:0] o_step;

  always #5 clk = ~clk;

  oven_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_btn_raw  (btn),
    .i_repeat_en(ren),
    .o_level    (o_level),
    .o_press    (o_press),
    .o_release  (o_release),
    .o_step     (o_step)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: raw history indexed by edge number plus per-channel timestamps.
  logic [4:0] raw_hist [HMAX];
  int         k        = 0;
  int         rst_edge = 0;
  logic [4:0] m_level  = '0;
  bit         m_pressed  [NCH];
  int         m_last_tog [NCH];
  int         m_last_ref [NCH];
  int         m_interval [NCH];

  int step_q  [NCH][$];
  int press_q [NCH][$];
  int rel_q   [NCH][$];

  // Synchronized value seen by the debouncer at edge j (two-edge delay, zero after reset).
  function automatic logic s_at(input int j, input int c);
    if (j - 2 <= rst_edge) return 1'b0;
    return raw_hist[j-2][c];
  endfunction

  function automatic int q_at(input int q[$], input int i);
    if (i < 0 || i >= q.size()) return -1000;
    return q[i];
  endfunction

  task automatic clear_q();
    for (int c = 0; c < NCH; c++) begin
      step_q[c].delete();
      press_q[c].delete();
      rel_q[c].delete();
    end
  endtask

  task automatic tick();
    logic [4:0] en;
    logic [4:0] e_pr;
    logic [4:0] e_rl;
    logic [4:0] e_st;
    bit         tog;
    k++;
    if (k >= HMAX) begin
      $display("FAIL history_overflow: got %0d expected below %0d", k, HMAX);
      $fatal(1, "history exhausted");
    end
    raw_hist[k] = btn;
    en = ren;
    @(posedge clk);
    #1;
    e_pr = '0;
    e_rl = '0;
    e_st = '0;
    for (int c = 0; c < NCH; c++) begin
      tog = (k - m_last_tog[c] >= D);
      for (int j = k - D + 1; j <= k; j++) begin
        if (s_at(j, c) == m_level[c]) tog = 0;
      end
      if (tog) begin
        m_last_tog[c] = k;
        if (!m_level[c]) begin
          e_pr[c] = 1'b1;
          e_st[c] = 1'b1;
          m_pressed[c]  = 1;
          m_last_ref[c] = k;
          m_interval[c] = RD;
        end else begin
          e_rl[c] = 1'b1;
          m_pressed[c] = 0;
        end
        m_level[c] = ~m_level[c];
      end else if (m_pressed[c]) begin
        if (!en[c]) begin
          m_last_ref[c] = k;
        end else if (k - m_last_ref[c] == m_interval[c]) begin
          e_st[c] = 1'b1;
          m_last_ref[c] = k;
          m_interval[c] = RR;
        end
      end
    end
    check($sformatf("outputs_cyc%0d", k),
          {12'h0, o_level, o_press, o_release, o_step},
          {12'h0, m_level, e_pr, e_rl, e_st});
    for (int c = 0; c < NCH; c++) begin
      if (o_step[c])    step_q[c].push_back(k);
      if (o_press[c])   press_q[c].push_back(k);
      if (o_release[c]) rel_q[c].push_back(k);
    end
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    #1;
    check("reset_async", {12'h0, o_level, o_press, o_release, o_step}, 32'h0);
    repeat (n) @(posedge clk);
    #1;
    check("reset_hold", {12'h0, o_level, o_press, o_release, o_step}, 32'h0);
    rst_n = 1'b1;
    m_level  = '0;
    rst_edge = k;
    for (int c = 0; c < NCH; c++) begin
      m_pressed[c]  = 0;
      m_last_tog[c] = k - D;
      m_last_ref[c] = k;
      m_interval[c] = RD;
    end
  endtask

  initial begin
    int b;
    int busy;

    apply_reset(3);

    // Clean press on B without repeat.
    clear_q();
    b = k;
    btn[1] = 1'b1;
    ren = '0;
    repeat (30) tick();
    check("clean_press_time", q_at(press_q[1], 0) - b, 6);
    check("clean_step_time", q_at(step_q[1], 0) - b, 6);
    check("clean_step_count", step_q[1].size(), 1);
    check("clean_level_held", {31'h0, o_level[1]}, 1);
    btn[1] = 1'b0;
    repeat (10) tick();
    check("clean_release_count", rel_q[1].size(), 1);

    // Glitch one short of the debounce length, then exactly the debounce length.
    clear_q();
    btn[2] = 1'b1;
    repeat (3) tick();
    btn[2] = 1'b0;
    repeat (12) tick();
    check("glitch_press_count", press_q[2].size(), 0);
    check("glitch_step_count", step_q[2].size(), 0);
    b = k;
    btn[2] = 1'b1;
    repeat (4) tick();
    btn[2] = 1'b0;
    repeat (14) tick();
    check("min_pulse_press_time", q_at(press_q[2], 0) - b, 6);
    check("min_pulse_release_count", rel_q[2].size(), 1);

    // Auto-repeat on A, then release.
    clear_q();
    b = k;
    ren[0] = 1'b1;
    btn[0] = 1'b1;
    repeat (23) tick();
    check("repeat_step0", q_at(step_q[0], 0) - b, 6);
    check("repeat_step1", q_at(step_q[0], 1) - b, 16);
    check("repeat_step2", q_at(step_q[0], 2) - b, 19);
    check("repeat_step3", q_at(step_q[0], 3) - b, 22);
    btn[0] = 1'b0;
    repeat (10) tick();
    check("repeat_release_time", q_at(rel_q[0], 0) - b, 29);
    check("repeat_last_step", q_at(step_q[0], step_q[0].size() - 1) - b, 28);
    check("repeat_step_count", step_q[0].size(), 6);
    ren = '0;

    // Simultaneous D and E.
    clear_q();
    b = k;
    btn[4:3] = 2'b11;
    repeat (8) tick();
    check("simul_press_d", q_at(press_q[3], 0) - b, 6);
    check("simul_press_e", q_at(press_q[4], 0) - b, 6);
    busy = 0;
    for (int c = 0; c < 3; c++) busy += press_q[c].size() + step_q[c].size();
    check("simul_others_idle", busy, 0);
    btn[4:3] = 2'b00;
    repeat (8) tick();

    // Reset in the middle of a repeating hold.
    clear_q();
    ren[0] = 1'b1;
    btn[0] = 1'b1;
    repeat (18) tick();
    apply_reset(2);
    clear_q();
    b = k;
    repeat (8) tick();
    check("post_reset_press", q_at(press_q[0], 0) - b, 6);
    check("post_reset_no_release", rel_q[0].size(), 0);
    btn[0] = 1'b0;
    ren = '0;
    repeat (10) tick();

    // Randomized traffic: slower-toggling channels reach the repeat region.
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range((4 << c) - 1) == 0) btn[c] = ~btn[c];
        if ($urandom_range(15) == 0) ren[c] = ~ren[c];
      end
      if ($urandom_range(799) == 0) apply_reset(int'($urandom_range(1, 3)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oven_button_conditioner.md
OVEN_BUTTON_CONDITIONER -- requirements
Module: oven_button_conditioner

Interface
REQ-001 The parameter DEBOUNCE_CYCLES SHALL default to 500000 and SHALL set the number of consecutive stable cycles needed to accept a level change (10 ms at 50 MHz).
REQ-002 The parameter REPEAT_DELAY SHALL default to 25000000 and SHALL set the cycles from an accepted press to the first auto-repeat step.
REQ-003 The parameter REPEAT_RATE SHALL default to 5000000 and SHALL set the cycles between subsequent auto-repeat steps.
REQ-004 clk  input  1  SHALL be the single system clock (50 MHz board clock).
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 btn_raw  input  5  SHALL carry the raw, asynchronous, active-high buttons; bit 0 is A and bit 4 is E.
REQ-007 repeat_en  input  5  SHALL carry per-button auto-repeat enables, sampled each cycle.
REQ-008 level  output  5  SHALL carry the debounced button levels.
REQ-009 press  output  5  SHALL pulse high for 1 cycle when level rises.
REQ-010 release  output  5  SHALL pulse high for 1 cycle when level falls.
REQ-011 step  output  5  SHALL pulse high for 1 cycle on each press and on each auto-repeat event; it feeds the temperature and bake-time increment logic.

Function
REQ-012 Each bit SHALL be processed by an identical, independent channel; no cross-channel interaction.
REQ-013 Each channel SHALL pass btn_raw through a 2-flop synchronizer; sync is the second flop.
REQ-014 The debounce counter (width $clog2(DEBOUNCE_CYCLES)+1) SHALL increment every cycle that sync != level and SHALL clear on any cycle that sync == level.
REQ-015 When the counter equals DEBOUNCE_CYCLES-1 and sync != level still holds, level SHALL toggle on the next edge and the counter SHALL clear.
REQ-016 A raw edge held stable SHALL therefore reach level exactly DEBOUNCE_CYCLES+2 cycles later; any glitch shorter than DEBOUNCE_CYCLES SHALL produce no level, press, release or step activity.
REQ-017 press and release SHALL be registered and asserted in the same cycle that level changes.
REQ-018 The per-channel FSM SHALL have the states UP, DOWN_WAIT and DOWN_REPEAT.
REQ-019 UP->DOWN_WAIT SHALL occur on a level rise, emitting step together with press and clearing the repeat counter.
REQ-020 In DOWN_WAIT, when the repeat counter reaches REPEAT_DELAY-1 with repeat_en=1, the FSM SHALL emit step, move to DOWN_REPEAT and clear the counter.
REQ-021 In DOWN_REPEAT, when the counter reaches REPEAT_RATE-1 with repeat_en=1, the FSM SHALL emit step and clear the counter.
REQ-022 Steps SHALL occur at press+REPEAT_DELAY, then every REPEAT_RATE cycles, without limit while held.
REQ-023 With repeat_en=0, the repeat counter SHALL hold at 0 and no repeat steps SHALL occur; re-asserting repeat_en SHALL restart the full REPEAT_DELAY or REPEAT_RATE interval from that cycle.
REQ-024 A level fall in any state SHALL return the FSM to UP, clear the repeat counter and suppress any step in that cycle.
REQ-025 The repeat counter width SHALL be sized for max(REPEAT_DELAY, REPEAT_RATE) and SHALL never wrap.
REQ-026 All parameters SHALL be at least 2; behaviour below 2 is unsupported.

Reset
REQ-027 While rst_n=0, all synchronizer flops, counters and outputs SHALL be 0 and all FSMs SHALL be in UP, asynchronously and regardless of clk.
REQ-028 A button held through reset release SHALL be treated as a new press: press and step after DEBOUNCE_CYCLES+2 cycles.
REQ-029 Reset asserted mid-hold or mid-repeat SHALL abort the hold immediately, with no release pulse generated.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3)
REQ-030 Clean press: btn_raw[1] rises at cycle 0 and holds, repeat_en=0 -> level[1], press[1] and step[1] high at cycle 6, with exactly one step.
REQ-031 Glitch: btn_raw[2] high for 3 cycles, then low -> level, press and step stay 0 throughout.
REQ-032 Auto-repeat: btn_raw[0] held, repeat_en[0]=1, press at cycle 6 -> step[0] at cycles 6, 16, 19 and 22.
REQ-033 Release: after REQ-032, btn_raw[0] falls at cycle 23 -> release[0] and level[0]=0 at cycle 29, with no step at or after cycle 29.
REQ-034 Simultaneous: btn_raw[4:3] rise in the same cycle -> press[4:3] both pulse in the same cycle, and channels 0-2 remain idle.
REQ-035 Reset mid-repeat: rst_n pulled low at cycle 18 of REQ-032 -> all outputs 0 immediately; after rst_n=1 with the button still held, press after 6 cycles.
